// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to uart_tx and uart_rx),
// data width and the bit-period helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Clock cycles per serial bit, truncated.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset value so an idle-high line does not look like an edge after reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default. Define UART_RX_PARITY_EN for 8E1 framing
// with parity checking (parity_err_o is tied low otherwise).
// Output is a single-entry valid/ready holding register; a byte completed
// while the previous one is still unaccepted is dropped and flagged.
import uart_pkg::*;

module uart_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] rx_data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      frame_err_o,
  output logic                      overrun_o,
  output logic                      parity_err_o
);

  // CPB must be at least 4 so the half-bit wait is non-zero.
  localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_state_e               state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [2:0]                bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      ferr_q;
  logic                      ovr_q;
  logic                      xfer;
  logic                      frame_ok;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q;
  logic                      perr_q;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i   (clk_i),
    .nreset_i(nreset_i),
    .d_i     (rx_i),
    .q_o     (rx_s)
  );

  assign xfer = valid_q & ready_i;

`ifdef UART_RX_PARITY_EN
  assign frame_ok = rx_s & ~par_bad_q;
`else
  assign frame_ok = rx_s;
`endif

  // Receive FSM with bit timing, shift register and registered outputs.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      // A commit later in this block overrides this clear.
      if (xfer) valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            state_q <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q          <= '0;
            shift_q[bit_q] <= rx_s;
            bit_q          <= bit_q + 3'd1;
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q     <= '0;
            par_bad_q <= (^shift_q) != rx_s;
            state_q   <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q <= '0;
            // Return to IDLE at mid-stop so a back-to-back start edge is seen.
            state_q <= rx_s ? ST_IDLE : ST_BREAK;
            if (!rx_s) ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) perr_q <= 1'b1;
`endif
            if (frame_ok) begin
              if (!valid_q || ready_i) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_BREAK: begin
          if (rx_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data_o   = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built from the serial-line rules,
// expected bytes are queued on issue and popped by a monitor on each transfer.
module tb_uart_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;

  logic       clk;
  logic       nreset_i;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk_i       (clk),
    .nreset_i    (nreset_i),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .parity_err_o(parity_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  int obs_ferr = 0, obs_ovr = 0, obs_perr = 0;

  task automatic check_eq(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pops an expected byte for every transfer and counts error pulse cycles.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (nreset_i) begin
        if (frame_err_o)  obs_ferr++;
        if (overrun_o)    obs_ovr++;
        if (parity_err_o) obs_perr++;
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h, expected no transfer", rx_data_o);
          end else begin
            check_eq("rx_data", int'(rx_data_o), int'(exp_q.pop_front()));
          end
        end
      end
    end
  endtask

  task automatic checkpoint(input string name);
    check_eq({name, " frame_err"}, obs_ferr, exp_ferr);
    check_eq({name, " overrun"}, obs_ovr, exp_ovr);
    check_eq({name, " parity_err"}, obs_perr, exp_perr);
    check_eq({name, " pending"}, exp_q.size(), 0);
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    tick(CPB);
  endtask

  // One frame; the expected outcome is recorded before the line is driven.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                            input bit par_ok, input bit overrun);
    bit commit;
    commit = stop_ok;
`ifdef UART_RX_PARITY_EN
    commit = commit && par_ok;
    if (!par_ok) exp_perr++;
`endif
    if (!stop_ok) exp_ferr++;
    if (commit) begin
      if (overrun) exp_ovr++;
      else exp_q.push_back(d);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ ~par_ok);
`endif
    drive_bit(stop_ok);
  endtask

  initial begin
    nreset_i = 1'b0;
    rx_i     = 1'b1;
    ready_i  = 1'b1;
    fork
      monitor();
    join_none
    tick(3);
    check_eq("reset rx_data", int'(rx_data_o), 0);
    check_eq("reset valid", int'(valid_o), 0);
    check_eq("reset frame_err", int'(frame_err_o), 0);
    check_eq("reset overrun", int'(overrun_o), 0);
    check_eq("reset parity_err", int'(parity_err_o), 0);
    nreset_i = 1'b1;
    tick(4);

    // Single frame.
    send_frame(8'h6C, 1, 1, 0);
    tick(CPB);
    checkpoint("single");

    // Back-to-back frames, no idle gap.
    send_frame(8'h6C, 1, 1, 0);
    send_frame(8'h88, 1, 1, 0);
    tick(CPB);
    checkpoint("b2b");

    // Short glitch must not start a frame.
    rx_i = 1'b0;
    tick(CPB / 4);
    rx_i = 1'b1;
    tick(2 * CPB);
    send_frame(8'h88, 1, 1, 0);
    tick(CPB);
    checkpoint("glitch");

    // Bad stop bit followed by a held-low line.
    send_frame(8'hA5, 0, 1, 0);
    rx_i = 1'b0;
    tick(3 * CPB);
    rx_i = 1'b1;
    tick(2 * CPB);
    send_frame(8'h5A, 1, 1, 0);
    tick(CPB);
    checkpoint("break");

    // Overrun while the consumer stalls.
    ready_i = 1'b0;
    send_frame(8'h6C, 1, 1, 0);
    send_frame(8'h88, 1, 1, 1);
    tick(4);
    check_eq("stall rx_data", int'(rx_data_o), 8'h6C);
    check_eq("stall valid", int'(valid_o), 1);
    ready_i = 1'b1;
    tick(3);
    check_eq("after accept valid", int'(valid_o), 0);
    checkpoint("overrun");

    // Reset in the middle of bit 4 drops the partial byte.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx_i = 1'b0;
    tick(CPB / 2);
    nreset_i = 1'b0;
    rx_i     = 1'b1;
    tick(2);
    check_eq("midreset rx_data", int'(rx_data_o), 0);
    check_eq("midreset valid", int'(valid_o), 0);
    check_eq("midreset frame_err", int'(frame_err_o), 0);
    check_eq("midreset overrun", int'(overrun_o), 0);
    check_eq("midreset parity_err", int'(parity_err_o), 0);
    nreset_i = 1'b1;
    tick(2 * CPB);
    send_frame(8'h3C, 1, 1, 0);
    tick(CPB);
    checkpoint("midreset");
`ifdef UART_RX_PARITY_EN
    send_frame(8'h3C, 1, 0, 0);
    tick(CPB);
    checkpoint("parity");
`endif

    // Randomised frames with occasional stop and parity faults.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      bit sok, pok;
      d   = 8'($urandom);
      sok = ($urandom_range(0, 5) != 0);
      pok = 1'b1;
`ifdef UART_RX_PARITY_EN
      pok = ($urandom_range(0, 5) != 0);
`endif
      send_frame(d, sok, pok, 0);
      if (!sok) begin
        rx_i = 1'b1;
        tick(2 * CPB);
      end else begin
        tick($urandom_range(0, CPB));
      end
    end
    tick(2 * CPB);
    checkpoint("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
